lsu_ctrl: RTL and testbench

Load/store sequencing controller for the uPower datapath. Accepts one D-form load or store at a time (lwz/lhz/lbz/stw), reads base and store data from the register file, computes the effective address, runs a request/acknowledge transaction against data memory, and writes load results back to the register file. Sits between the decode stage and the register file / data memory, owning both of their ports for the duration of each operation.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 36 +++
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller: op encodings,
// controller states, byte-enable lane patterns and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LWZ = 2'b00,
    OP_LHZ = 2'b01,
    OP_LBZ = 2'b10,
    OP_STW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RF   = 2'b01,
    MEM  = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic misaligned(input op_e op, input logic [1:0] ea_lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LWZ, OP_STW: bad = (ea_lo != 2'b00);
      OP_LHZ:         bad = ea_lo[0];
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables from op and EA[1:0], and zero-extended load
// data extracted from the little-endian memory word. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] ldata
);

  always_comb begin
    be    = BE_NONE;
    ldata = '0;
    case (op)
      OP_LWZ: begin
        be    = BE_WORD;
        ldata = rdata;
      end
      OP_LHZ: begin
        be    = BE_HALF << ea_lo;
        ldata = 32'(16'(rdata >> {ea_lo, 3'b000}));
      end
      OP_LBZ: begin
        be    = BE_BYTE << ea_lo;
        ldata = 32'(8'(rdata >> {ea_lo, 3'b000}));
      end
      default: begin
        be    = BE_WORD;
        ldata = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequences one D-form load/store: RF read, EA + alignment check, memory
// req/ack with timeout, then load writeback; outputs decode from state only.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [4:0]        issue_ra,
  input  logic [4:0]        issue_rt,
  input  logic [15:0]       issue_d,
  output logic [4:0]        rf_raddr_a,
  output logic [4:0]        rf_raddr_b,
  input  logic [31:0]       rf_rdata_a,
  input  logic [31:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  ra_q, ra_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] d_q, d_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [3:0]  align_be;
  logic [31:0] align_ldata;

  lsu_align u_align (
    .op    (op_q),
    .ea_lo (ea_q[1:0]),
    .rdata (mem_rdata),
    .be    (align_be),
    .ldata (align_ldata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rt_d    = rt_q;
    d_d     = d_q;
    ea_d    = ea_q;
    sdata_d = sdata_q;
    ldata_d = ldata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    issue_ready = (state_q == IDLE);
    rf_raddr_a  = (state_q == RF) ? ra_q : 5'd0;
    rf_raddr_b  = (state_q == RF) ? rt_q : 5'd0;
    mem_req     = (state_q == MEM);
    mem_we      = (state_q == MEM) && (op_q == OP_STW);
    mem_addr    = (state_q == MEM) ? ea_q[ADDR_W-1:0] : '0;
    mem_be      = (state_q == MEM) ? align_be : BE_NONE;
    mem_wdata   = ((state_q == MEM) && (op_q == OP_STW)) ? sdata_q : 32'd0;
    done        = (state_q == RESP);
    err         = (state_q == RESP) && err_q;
    rf_we       = (state_q == RESP) && !err_q && (op_q != OP_STW);
    rf_waddr    = rf_we ? rt_q : 5'd0;
    rf_wdata    = rf_we ? ldata_q : 32'd0;

    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          op_d    = op_e'(issue_op);
          ra_d    = issue_ra;
          rt_d    = issue_rt;
          d_d     = issue_d;
          state_d = RF;
        end
      end
      RF: begin
        // r0 as a base reads as zero; as a load target it is a real register
        ea_d    = ((ra_q == 5'd0) ? 32'd0 : rf_rdata_a) + {{16{d_q[15]}}, d_q};
        sdata_d = rf_rdata_b;
        cnt_d   = 8'd0;
        if (misaligned(op_q, ea_d[1:0])) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          err_d   = 1'b0;
          state_d = MEM;
        end
      end
      MEM: begin
        // ack is checked first so an ack on the final allowed cycle succeeds
        if (mem_ack) begin
          ldata_d = align_ldata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_LWZ;
      ra_q    <= '0;
      rt_q    <= '0;
      d_q     <= '0;
      ea_q    <= '0;
      sdata_q <= '0;
      ldata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rt_q    <= rt_d;
      d_q     <= d_d;
      ea_q    <= ea_d;
      sdata_q <= sdata_d;
      ldata_q <= ldata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected completions are queued at issue and
// popped when done pulses; a behavioural memory acks after a programmable wait.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_op;
  logic [4:0]        issue_ra;
  logic [4:0]        issue_rt;
  logic [15:0]       issue_d;
  logic [4:0]        rf_raddr_a;
  logic [4:0]        rf_raddr_b;
  logic [31:0]       rf_rdata_a;
  logic [31:0]       rf_rdata_b;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              done;
  logic              err;

  lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_ra(issue_ra), .issue_rt(issue_rt), .issue_d(issue_d),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];
  always_comb begin
    rf_rdata_a = regs[rf_raddr_a];
    rf_rdata_b = regs[rf_raddr_b];
  end

  // Memory model: ack_wait = number of MEM cycles before the ack cycle; -1 never acks
  int          ack_wait;
  logic [31:0] rdata_val;
  int          req_cnt;
  initial begin
    mem_ack = 1'b0;
    req_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        req_cnt = 0;
        mem_ack = 1'b0;
      end else begin
        mem_ack = (ack_wait >= 0) && (req_cnt == ack_wait);
        req_cnt++;
      end
    end
  end
  assign mem_rdata = rdata_val;

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          lat;
    int          req;
  } exp_t;
  exp_t exp_q[$];

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // Observations from the last operation
  logic              obs_found;
  int                obs_lat;
  logic              obs_err, obs_we, obs_stable, obs_stray_we;
  logic [4:0]        obs_waddr;
  logic [31:0]       obs_wdata;
  int                obs_req;
  logic              first_we;
  logic [ADDR_W-1:0] first_addr;
  logic [3:0]        first_be;
  logic [31:0]       first_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] op, input logic [4:0] ra,
                          input logic [4:0] rt, input logic [15:0] d);
    for (int g = 0; g < 50 && !issue_ready; g++) tick();
    issue_op    = op;
    issue_ra    = ra;
    issue_rt    = rt;
    issue_d     = d;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    issue_op    = 2'b00;
    issue_ra    = 5'd0;
    issue_rt    = 5'd0;
    issue_d     = 16'd0;
  endtask

  // Issues one op and records what the DUT does until done (bounded); returns in the done cycle
  task automatic run_op(input logic [1:0] op, input logic [4:0] ra,
                        input logic [4:0] rt, input logic [15:0] d);
    obs_found = 1'b0; obs_lat = -1; obs_err = 1'b0; obs_we = 1'b0;
    obs_waddr = '0; obs_wdata = '0; obs_req = 0; obs_stable = 1'b1; obs_stray_we = 1'b0;
    do_issue(op, ra, rt, d);
    for (int c = 1; c <= 60; c++) begin
      if (mem_req) begin
        if (obs_req == 0) begin
          first_we = mem_we; first_addr = mem_addr; first_be = mem_be; first_wdata = mem_wdata;
        end else if (mem_we !== first_we || mem_addr !== first_addr ||
                     mem_be !== first_be || mem_wdata !== first_wdata) begin
          obs_stable = 1'b0;
        end
        obs_req++;
      end
      if (rf_we && !done) obs_stray_we = 1'b1;
      if (done) begin
        obs_found = 1'b1; obs_lat = c; obs_err = err; obs_we = rf_we;
        obs_waddr = rf_waddr; obs_wdata = rf_wdata;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    cmp_cnt++; if (issue_ready !== 1'b1) begin mis_cnt++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    cmp_cnt++; if ({mem_req, mem_we, done, err, rf_we} !== 5'b0) begin mis_cnt++; $display("FAIL reset_ctrl: got req/we/done/err/rfwe=%b want 00000", {mem_req, mem_we, done, err, rf_we}); end
    cmp_cnt++; if ({mem_addr, mem_be, mem_wdata} !== '0) begin mis_cnt++; $display("FAIL reset_mem_bus: got addr=%h be=%b wdata=%h want zeros", mem_addr, mem_be, mem_wdata); end
    cmp_cnt++; if ({rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b} !== '0) begin mis_cnt++; $display("FAIL reset_rf_bus: got waddr=%0d wdata=%h ra=%0d rb=%0d want zeros", rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lwz();
    exp_t e;
    regs[1] = 32'h100; ack_wait = 0; rdata_val = 32'hDEADBEEF;
    exp_q.push_back('{err: 1'b0, we: 1'b1, waddr: 5'd5, wdata: 32'hDEADBEEF, lat: 3, req: 1});
    run_op(2'b00, 5'd1, 5'd5, 16'h0008);
    e = exp_q.pop_front();
    cmp_cnt++; if (!obs_found || obs_lat != e.lat) begin mis_cnt++; $display("FAIL lwz_latency: got found=%b lat=%0d want lat=%0d", obs_found, obs_lat, e.lat); end
    cmp_cnt++; if (first_addr !== 32'h108 || first_be !== 4'b1111 || first_we !== 1'b0) begin mis_cnt++; $display("FAIL lwz_mem: got addr=%h be=%b we=%b want 108 1111 0", first_addr, first_be, first_we); end
    cmp_cnt++; if ({obs_err, obs_we, obs_waddr, obs_wdata} !== {e.err, e.we, e.waddr, e.wdata}) begin mis_cnt++; $display("FAIL lwz_wb: got err=%b we=%b r%0d=%h want err=%b we=%b r%0d=%h", obs_err, obs_we, obs_waddr, obs_wdata, e.err, e.we, e.waddr, e.wdata); end
    tick();
    cmp_cnt++; if (issue_ready !== 1'b1 || done !== 1'b0) begin mis_cnt++; $display("FAIL lwz_ready_after: got ready=%b done=%b want 1 0", issue_ready, done); end
  endtask

  task automatic test_lbz_wrap();
    exp_t e;
    ack_wait = 0; rdata_val = 32'hAABBCCDD;
    exp_q.push_back('{err: 1'b0, we: 1'b1, waddr: 5'd0, wdata: 32'h000000AA, lat: 3, req: 1});
    run_op(2'b10, 5'd0, 5'd0, 16'hFFFF);
    e = exp_q.pop_front();
    cmp_cnt++; if (first_addr !== 32'hFFFFFFFF || first_be !== 4'b1000) begin mis_cnt++; $display("FAIL lbz_mem: got addr=%h be=%b want ffffffff 1000", first_addr, first_be); end
    cmp_cnt++; if (!obs_found || {obs_err, obs_we, obs_waddr, obs_wdata} !== {e.err, e.we, e.waddr, e.wdata}) begin mis_cnt++; $display("FAIL lbz_wb: got found=%b err=%b we=%b r%0d=%h want r%0d=%h", obs_found, obs_err, obs_we, obs_waddr, obs_wdata, e.waddr, e.wdata); end
    tick();
  endtask

  task automatic test_lhz_upper();
    exp_t e;
    regs[6] = 32'h100; ack_wait = 0; rdata_val = 32'hAABBCCDD;
    exp_q.push_back('{err: 1'b0, we: 1'b1, waddr: 5'd9, wdata: 32'h0000AABB, lat: 3, req: 1});
    run_op(2'b01, 5'd6, 5'd9, 16'h0002);
    e = exp_q.pop_front();
    cmp_cnt++; if (first_addr !== 32'h102 || first_be !== 4'b1100) begin mis_cnt++; $display("FAIL lhz_mem: got addr=%h be=%b want 102 1100", first_addr, first_be); end
    cmp_cnt++; if (!obs_found || {obs_err, obs_we, obs_waddr, obs_wdata} !== {e.err, e.we, e.waddr, e.wdata}) begin mis_cnt++; $display("FAIL lhz_wb: got found=%b err=%b we=%b r%0d=%h want r%0d=%h", obs_found, obs_err, obs_we, obs_waddr, obs_wdata, e.waddr, e.wdata); end
    tick();
  endtask

  task automatic test_stw_wait();
    exp_t e;
    regs[2] = 32'h200; regs[3] = 32'h12345678; ack_wait = 3; rdata_val = 32'h0;
    exp_q.push_back('{err: 1'b0, we: 1'b0, waddr: 5'd0, wdata: 32'h0, lat: 6, req: 4});
    run_op(2'b11, 5'd2, 5'd3, 16'hFFFC);
    e = exp_q.pop_front();
    cmp_cnt++; if (first_addr !== 32'h1FC || first_we !== 1'b1 || first_be !== 4'b1111 || first_wdata !== 32'h12345678) begin mis_cnt++; $display("FAIL stw_mem: got addr=%h we=%b be=%b wdata=%h want 1fc 1 1111 12345678", first_addr, first_we, first_be, first_wdata); end
    cmp_cnt++; if (obs_stable !== 1'b1 || obs_req != e.req) begin mis_cnt++; $display("FAIL stw_hold: got stable=%b req_cycles=%0d want 1 %0d", obs_stable, obs_req, e.req); end
    cmp_cnt++; if (!obs_found || obs_lat != e.lat || obs_err !== e.err || obs_we !== e.we || obs_stray_we) begin mis_cnt++; $display("FAIL stw_done: got found=%b lat=%0d err=%b we=%b stray=%b want lat=%0d err=0 we=0", obs_found, obs_lat, obs_err, obs_we, obs_stray_we, e.lat); end
    tick();
  endtask

  task automatic test_misaligned();
    exp_t e;
    regs[1] = 32'h100; ack_wait = 0;
    exp_q.push_back('{err: 1'b1, we: 1'b0, waddr: 5'd0, wdata: 32'h0, lat: 2, req: 0});
    run_op(2'b01, 5'd1, 5'd4, 16'h0001);
    e = exp_q.pop_front();
    cmp_cnt++; if (!obs_found || obs_lat != e.lat || obs_err !== e.err) begin mis_cnt++; $display("FAIL misalign_done: got found=%b lat=%0d err=%b want lat=%0d err=1", obs_found, obs_lat, obs_err, e.lat); end
    cmp_cnt++; if (obs_req != e.req || obs_we !== e.we || obs_stray_we) begin mis_cnt++; $display("FAIL misalign_side: got req_cycles=%0d we=%b stray=%b want 0 0 0", obs_req, obs_we, obs_stray_we); end
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    regs[1] = 32'h100; ack_wait = -1; rdata_val = 32'h0000_55AA;
    exp_q.push_back('{err: 1'b1, we: 1'b0, waddr: 5'd0, wdata: 32'h0, lat: TIMEOUT + 2, req: TIMEOUT});
    run_op(2'b00, 5'd1, 5'd4, 16'h0000);
    e = exp_q.pop_front();
    cmp_cnt++; if (obs_req != e.req) begin mis_cnt++; $display("FAIL timeout_req_cycles: got %0d want %0d", obs_req, e.req); end
    cmp_cnt++; if (!obs_found || obs_lat != e.lat || obs_err !== e.err || obs_we !== e.we || obs_stray_we) begin mis_cnt++; $display("FAIL timeout_done: got found=%b lat=%0d err=%b we=%b want lat=%0d err=1 we=0", obs_found, obs_lat, obs_err, obs_we, e.lat); end
    tick();
    ack_wait = TIMEOUT - 1;
    exp_q.push_back('{err: 1'b0, we: 1'b1, waddr: 5'd4, wdata: 32'h0000_55AA, lat: TIMEOUT + 2, req: TIMEOUT});
    run_op(2'b00, 5'd1, 5'd4, 16'h0000);
    e = exp_q.pop_front();
    cmp_cnt++; if (obs_req != e.req || !obs_found || obs_lat != e.lat) begin mis_cnt++; $display("FAIL late_ack_timing: got req_cycles=%0d lat=%0d want %0d %0d", obs_req, obs_lat, e.req, e.lat); end
    cmp_cnt++; if ({obs_err, obs_we, obs_waddr, obs_wdata} !== {e.err, e.we, e.waddr, e.wdata}) begin mis_cnt++; $display("FAIL late_ack_wb: got err=%b we=%b r%0d=%h want err=0 we=1 r%0d=%h", obs_err, obs_we, obs_waddr, obs_wdata, e.waddr, e.wdata); end
    tick();
  endtask

  task automatic test_reset_mid_mem();
    exp_t e;
    regs[1] = 32'h100; ack_wait = -1;
    do_issue(2'b00, 5'd1, 5'd7, 16'h0004);
    tick();
    cmp_cnt++; if (mem_req !== 1'b1) begin mis_cnt++; $display("FAIL midmem_req_up: got %b want 1", mem_req); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cmp_cnt++; if (mem_req !== 1'b0 || issue_ready !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0) begin mis_cnt++; $display("FAIL midmem_reset: got req=%b ready=%b done=%b rfwe=%b want 0 1 0 0", mem_req, issue_ready, done, rf_we); end
    ack_wait = 0; rdata_val = 32'hCAFEF00D;
    exp_q.push_back('{err: 1'b0, we: 1'b1, waddr: 5'd7, wdata: 32'hCAFEF00D, lat: 3, req: 1});
    run_op(2'b00, 5'd1, 5'd7, 16'h0004);
    e = exp_q.pop_front();
    cmp_cnt++; if (!obs_found || obs_lat != e.lat || first_addr !== 32'h104 || {obs_err, obs_we, obs_waddr, obs_wdata} !== {e.err, e.we, e.waddr, e.wdata}) begin mis_cnt++; $display("FAIL post_reset_lwz: got lat=%0d addr=%h err=%b we=%b r%0d=%h want lat=3 addr=104 r7=%h", obs_lat, first_addr, obs_err, obs_we, obs_waddr, obs_wdata, e.wdata); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    reset = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; issue_ra = 5'd0;
    issue_rt = 5'd0; issue_d = 16'd0; ack_wait = -1; rdata_val = 32'h0;
    test_reset();
    test_lwz();
    test_lbz_wrap();
    test_lhz_upper();
    test_stw_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
